// File: rtl/stage_mem_wb_if.sv
// rtl/stage_mem_wb_if.sv - execute/memory/register-file bundle for stage_mem_wb
interface stage_mem_wb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_instruction;
  logic [DATA_WIDTH-1:0]     in_alu_result;
  logic [DATA_WIDTH-1:0]     in_store_data;
  logic                      mem_req;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      mem_ack;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;
  logic                      illegal_op;
  logic                      mem_err;

  // Stage view: consumes execute and memory responses, drives memory and register file
  modport slave (
    input  in_valid, in_instruction, in_alu_result, in_store_data,
    input  mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output rf_we, rf_waddr, rf_wdata, illegal_op, mem_err
  );

  // Environment view: execute stage, data memory and register file
  modport master (
    output in_valid, in_instruction, in_alu_result, in_store_data,
    output mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  rf_we, rf_waddr, rf_wdata, illegal_op, mem_err
  );
endinterface

// File: rtl/stage_mem_wb.sv
// rtl/stage_mem_wb.sv - memory access and writeback stage (optional counters: STAGE_MEM_WB_PERF_EN)
module stage_mem_wb #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef STAGE_MEM_WB_PERF_EN
  output logic [31:0]           retired_count,
  output logic [31:0]           stall_cycles,
`endif
  stage_mem_wb_if.slave         bus
);

  localparam logic [6:0]  OP_NOP   = 7'h00;
  localparam logic [6:0]  OP_ALU   = 7'h01;
  localparam logic [6:0]  OP_LOAD  = 7'h02;
  localparam logic [6:0]  OP_STORE = 7'h03;
  localparam logic [31:0] TMO_LAST = 32'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                    state;
  logic [31:0]               tmo_count;
  logic [REG_ADDR_WIDTH-1:0] lat_dest;
  logic                      lat_is_load;

  logic                      accept;
  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] dest;
  logic                      op_other;
  logic                      unused_fields;

  // Instruction decode of the word currently offered by execute
  assign opcode   = bus.in_instruction[6:0];
  assign dest     = bus.in_instruction[12 +: REG_ADDR_WIDTH];
  assign op_other = (opcode != OP_ALU) && (opcode != OP_LOAD) && (opcode != OP_STORE);
  assign unused_fields = &{1'b0, bus.in_instruction[31:17], bus.in_instruction[11:7]};

  // Only the memory phase stalls execute; WB can take a new instruction
  assign bus.in_ready = (state != S_MEM);
  assign accept       = bus.in_valid && bus.in_ready;

  // Main sequencer: accept, memory handshake with timeout, one-cycle writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      tmo_count      <= '0;
      lat_dest       <= '0;
      lat_is_load    <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.rf_we      <= 1'b0;
      bus.rf_waddr   <= '0;
      bus.rf_wdata   <= '0;
      bus.illegal_op <= 1'b0;
      bus.mem_err    <= 1'b0;
    end else begin
      bus.rf_we      <= 1'b0;
      bus.illegal_op <= 1'b0;
      bus.mem_err    <= 1'b0;
      case (state)
        S_IDLE, S_WB: begin
          state <= S_IDLE;
          if (accept) begin
            lat_dest <= dest;
            case (opcode)
              OP_ALU: begin
                state        <= S_WB;
                bus.rf_we    <= (dest != '0);
                bus.rf_waddr <= dest;
                bus.rf_wdata <= bus.in_alu_result;
              end
              OP_LOAD, OP_STORE: begin
                state         <= S_MEM;
                tmo_count     <= '0;
                lat_is_load   <= (opcode == OP_LOAD);
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= (opcode == OP_STORE);
                bus.mem_addr  <= bus.in_alu_result;
                bus.mem_wdata <= bus.in_store_data;
              end
              OP_NOP: ;
              default: bus.illegal_op <= 1'b1;
            endcase
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (lat_is_load) begin
              state        <= S_WB;
              bus.rf_we    <= (lat_dest != '0);
              bus.rf_waddr <= lat_dest;
              bus.rf_wdata <= bus.mem_rdata;
            end else begin
              state <= S_IDLE;
            end
          end else if ((MEM_TIMEOUT != 0) && (tmo_count == TMO_LAST)) begin
            bus.mem_req <= 1'b0;
            bus.mem_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmo_count <= tmo_count + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STAGE_MEM_WB_PERF_EN
  logic [1:0] retire_inc;

  // Up to two retirements per edge: a WB cycle plus a NOP/illegal accepted during it
  always_comb begin
    retire_inc = 2'd0;
    if (state == S_WB)
      retire_inc = retire_inc + 2'd1;
    if (accept && op_other)
      retire_inc = retire_inc + 2'd1;
    if ((state == S_MEM) && bus.mem_ack && !lat_is_load)
      retire_inc = retire_inc + 2'd1;
  end

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_count <= '0;
      stall_cycles  <= '0;
    end else begin
      retired_count <= retired_count + 32'(retire_inc);
      if (bus.in_valid && !bus.in_ready)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_mem_wb.sv
// tb/tb_stage_mem_wb.sv - directed self-checking bench for stage_mem_wb
module tb_stage_mem_wb;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   rf_writes;
  int   illegals;

`ifdef STAGE_MEM_WB_PERF_EN
  logic [31:0] retired_count;
  logic [31:0] stall_cycles;
`endif

  stage_mem_wb_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  stage_mem_wb #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef STAGE_MEM_WB_PERF_EN
    .retired_count(retired_count),
    .stall_cycles(stall_cycles),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sdata);
    bus.in_valid       = 1'b1;
    bus.in_instruction = instr;
    bus.in_alu_result  = alu;
    bus.in_store_data  = sdata;
  endtask

  task automatic idle_in();
    bus.in_valid       = 1'b0;
    bus.in_instruction = 32'h0;
    bus.in_alu_result  = 32'h0;
    bus.in_store_data  = 32'h0;
  endtask

  logic [31:0] s_instr [8];
  logic [31:0] s_alu   [8];
  logic        s_we    [8];
  logic [4:0]  s_dest  [8];
  logic        s_ill   [8];

  initial begin
    total = 0; bad = 0; rf_writes = 0; illegals = 0;
    rst = 1'b0;
    idle_in();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'h0);
    check("rst_flags", {30'h0, bus.illegal_op, bus.mem_err}, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // ALU dest 3
    offer(32'h0000_3081, 32'hDEAD_BEEF, 32'h0);
    tick();
    idle_in();
    check("alu_rf_we", 32'(bus.rf_we), 32'd1);
    check("alu_rf_waddr", 32'(bus.rf_waddr), 32'd3);
    check("alu_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    check("alu_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("alu_rf_we_drop", 32'(bus.rf_we), 32'd0);

    // LOAD dest 5, ack sampled on the 4th edge (also the timeout edge: ack wins)
    offer(32'h0000_5002, 32'h0000_0100, 32'h0);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ld_req_%0d", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("ld_we_%0d", i), 32'(bus.mem_we), 32'd0);
      check($sformatf("ld_addr_%0d", i), bus.mem_addr, 32'h0000_0100);
      check($sformatf("ld_rdy_%0d", i), 32'(bus.in_ready), 32'd0);
      if (i == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    check("ld_req_drop", 32'(bus.mem_req), 32'd0);
    check("ld_rf_we", 32'(bus.rf_we), 32'd1);
    check("ld_rf_waddr", 32'(bus.rf_waddr), 32'd5);
    check("ld_rf_wdata", bus.rf_wdata, 32'h1234_5678);
    check("ld_no_err", 32'(bus.mem_err), 32'd0);
    check("ld_wb_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("ld_rf_we_drop", 32'(bus.rf_we), 32'd0);

    // STORE, ack after 1 cycle
    offer(32'h0000_0003, 32'h0000_0040, 32'hA5A5_A5A5);
    tick();
    idle_in();
    check("st_req", 32'(bus.mem_req), 32'd1);
    check("st_we", 32'(bus.mem_we), 32'd1);
    check("st_addr", bus.mem_addr, 32'h0000_0040);
    check("st_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("st_req_drop", 32'(bus.mem_req), 32'd0);
    check("st_no_rf_we", 32'(bus.rf_we), 32'd0);
    check("st_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("st_idle_rf_we", 32'(bus.rf_we), 32'd0);

    // LOAD with no ack: timeout after 4 cycles
    offer(32'h0000_7002, 32'h0000_0200, 32'h0);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_%0d", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("to_err_%0d", i), 32'(bus.mem_err), 32'd0);
      tick();
    end
    check("to_req_drop", 32'(bus.mem_req), 32'd0);
    check("to_err_pulse", 32'(bus.mem_err), 32'd1);
    check("to_no_rf_we", 32'(bus.rf_we), 32'd0);
    check("to_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("to_err_drop", 32'(bus.mem_err), 32'd0);
    check("to_rf_we_after", 32'(bus.rf_we), 32'd0);

    // Back-to-back stream: dest 0 and opcode 7F included
    s_instr = '{32'h0000_1001, 32'h0000_2001, 32'h0000_0001, 32'h0000_3001,
                32'h0000_907F, 32'h0000_4001, 32'h0000_5001, 32'h0000_6001};
    s_we    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    s_dest  = '{5'd1, 5'd2, 5'd0, 5'd3, 5'd9, 5'd4, 5'd5, 5'd6};
    s_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) s_alu[i] = 32'h1111_0000 + 32'(i);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("str_rdy_%0d", i), 32'(bus.in_ready), 32'd1);
      offer(s_instr[i], s_alu[i], 32'h0);
      tick();
      check($sformatf("str_we_%0d", i), 32'(bus.rf_we), 32'(s_we[i]));
      check($sformatf("str_ill_%0d", i), 32'(bus.illegal_op), 32'(s_ill[i]));
      if (s_we[i]) begin
        check($sformatf("str_addr_%0d", i), 32'(bus.rf_waddr), 32'(s_dest[i]));
        check($sformatf("str_data_%0d", i), bus.rf_wdata, s_alu[i]);
      end
      if (bus.rf_we) rf_writes++;
      if (bus.illegal_op) illegals++;
    end
    idle_in();
    tick();
    check("str_tail_we", 32'(bus.rf_we), 32'd0);
    check("str_rf_writes", 32'(rf_writes), 32'd6);
    check("str_illegals", 32'(illegals), 32'd1);
`ifdef STAGE_MEM_WB_PERF_EN
    check("perf_retired", retired_count, 32'd11);
    check("perf_stall", stall_cycles, 32'd0);
`endif

    // Reset during the 2nd MEM cycle
    offer(32'h0000_5002, 32'h0000_0300, 32'h0);
    tick();
    idle_in();
    tick();
    check("rm_req_before", 32'(bus.mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rm_req_async", 32'(bus.mem_req), 32'd0);
    check("rm_ready_async", 32'(bus.in_ready), 32'd1);
    check("rm_rf_we_async", 32'(bus.rf_we), 32'd0);
`ifdef STAGE_MEM_WB_PERF_EN
    check("rm_perf_retired", retired_count, 32'd0);
    check("rm_perf_stall", stall_cycles, 32'd0);
`endif
    tick();
    rst = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.mem_ack = 1'b0;
    check("rm_stray_ack_rf_we", 32'(bus.rf_we), 32'd0);
    check("rm_stray_ack_req", 32'(bus.mem_req), 32'd0);
    tick();
    check("rm_after_rf_we", 32'(bus.rf_we), 32'd0);
    check("rm_after_ready", 32'(bus.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
